// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline registers of the 5-stage RISC core.
// Provides the datapath widths and the control bundle layout so that the
// ID/EX, EX/MEM and MEM/WB registers all use the same field order.
package pipeline_pkg;

  localparam int DATA_W = 16;  // ALU result / store data width
  localparam int REG_AW = 3;   // register index width (8 registers)
  localparam int PC_W   = 16;  // carried PC width

  // Control bundle, field order {reg_write, mem_read, mem_write}
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Gate every control bit with the slot's valid flag so a bubble can never
  // cause a register-file or memory side effect downstream.
  function automatic ctrl_t qualify_ctrl(input ctrl_t c, input logic v);
    ctrl_t q;
    q.reg_write = c.reg_write & v;
    q.mem_read  = c.mem_read  & v;
    q.mem_write = c.mem_write & v;
    return q;
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset, clears q
//   stall  - hold q this cycle
//   flush  - clear q (CLEAR_ON_FLUSH=1) or hold q (CLEAR_ON_FLUSH=0)
//   d      - next value
//   q      - registered value
// Priority: reset > flush > stall > load.
module pipe_field_reg #(
  parameter int W              = 8,
  parameter bit CLEAR_ON_FLUSH = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Field storage with reset / flush / stall / load priority
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= {W{1'b0}};
    end else if (flush && CLEAR_ON_FLUSH) begin
      q <= {W{1'b0}};
    end else if (stall || flush) begin
      // A flush on a non-clearing field leaves it untouched: the data is
      // don't-care once the valid/control copy has been cleared.
      q <= q;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_pipeline_reg.sv
// EX/MEM pipeline register.
// Captures the EX-stage result, store data, destination, PC and control bits
// and presents them to MEM. Also drives the forwarding qualifier and the
// load-use hazard request against the instruction currently in ID/EX.
// Ports:
//   i_clk, i_reset           - clock, synchronous active-high reset
//   i_stall, i_flush         - hold contents / insert bubble
//   i_valid, i_alu_result, i_store_data, i_rd, i_pc,
//   i_reg_write, i_mem_read, i_mem_write - EX-stage instruction
//   i_rs_idex, i_rt_idex     - sources of the ID/EX instruction
//   o_valid .. o_mem_write   - registered MEM-stage view
//   o_fwd_en                 - forwarding qualifier (combinational)
//   o_load_use_hazard        - load-use stall request (combinational)
module ex_mem_pipeline_reg #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int REG_AW = pipeline_pkg::REG_AW,
  parameter int PC_W   = pipeline_pkg::PC_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_reg_write,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [REG_AW-1:0] i_rs_idex,
  input  logic [REG_AW-1:0] i_rt_idex,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_store_data,
  output logic [REG_AW-1:0] o_rd_exmem,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_reg_write,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_fwd_en,
  output logic              o_load_use_hazard
);

  import pipeline_pkg::*;

  localparam int DW = 2 * DATA_W + REG_AW + PC_W;
  localparam int VW = CTRL_W + 1;

  logic [DW-1:0] data_d_s;
  logic [DW-1:0] data_q_r;
  ctrl_t         ctrl_in_s;
  ctrl_t         ctrl_q_r;
  logic          valid_q_r;
  logic [VW-1:0] vc_d_s;
  logic [VW-1:0] vc_q_r;
  logic          rs_match_s;
  logic          rt_match_s;

  assign ctrl_in_s = qualify_ctrl(ctrl_t'({i_reg_write, i_mem_read, i_mem_write}), i_valid);
  assign vc_d_s    = {i_valid, ctrl_in_s};
  assign data_d_s  = {i_alu_result, i_store_data, i_rd, i_pc};

  // Data fields keep their contents on flush; only valid/control are cleared.
  pipe_field_reg #(.W(DW), .CLEAR_ON_FLUSH(1'b0)) u_data_reg (
    .clk   (i_clk),
    .reset (i_reset),
    .stall (i_stall),
    .flush (i_flush),
    .d     (data_d_s),
    .q     (data_q_r)
  );

  pipe_field_reg #(.W(VW), .CLEAR_ON_FLUSH(1'b1)) u_ctrl_reg (
    .clk   (i_clk),
    .reset (i_reset),
    .stall (i_stall),
    .flush (i_flush),
    .d     (vc_d_s),
    .q     (vc_q_r)
  );

  assign {valid_q_r, ctrl_q_r} = vc_q_r;
  assign {o_alu_result, o_store_data, o_rd_exmem, o_pc} = data_q_r;

  assign o_valid     = valid_q_r;
  assign o_reg_write = ctrl_q_r.reg_write;
  assign o_mem_read  = ctrl_q_r.mem_read;
  assign o_mem_write = ctrl_q_r.mem_write;

  // Forwarding qualifier and load-use detection from the held register contents
  always_comb begin
    rs_match_s = 1'b0;
    rt_match_s = 1'b0;
    if (o_rd_exmem == i_rs_idex) begin
      rs_match_s = 1'b1;
    end else begin
      rs_match_s = 1'b0;
    end
    if (o_rd_exmem == i_rt_idex) begin
      rt_match_s = 1'b1;
    end else begin
      rt_match_s = 1'b0;
    end
    // A load's data only exists after MEM, so it must never be forwarded here.
    o_fwd_en          = valid_q_r & ctrl_q_r.reg_write & ~ctrl_q_r.mem_read;
    o_load_use_hazard = valid_q_r & ctrl_q_r.mem_read & (rs_match_s | rt_match_s);
  end

endmodule

// File: doc/ex_mem_pipeline_reg.md
Name: ex_mem_pipeline_reg

Overview:
- EX/MEM pipeline register for the 5-stage RISC core.
- Captures ALU result, destination register, store data and control bits at the end of EX, and presents them to MEM.
- Supplies the forwarding unit with the EX/MEM destination register and a qualified forward-enable.
- Detects load-use hazards against the instruction currently in ID/EX.

Parameters:
- DATA_W, 16, width of ALU result and store data
- REG_AW, 3, register index width (8 architectural registers)
- PC_W, 16, width of carried PC (used for exceptions and CALL)

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_reset  input  1  synchronous active-high reset
- i_stall  input  1  hold all contents this cycle
- i_flush  input  1  replace contents with a bubble this cycle
- i_valid  input  1  EX stage holds a real instruction
- i_alu_result  input  DATA_W  ALU output
- i_store_data  input  DATA_W  forwarded data2 for stores
- i_rd  input  REG_AW  destination register
- i_pc  input  PC_W  PC of the EX instruction
- i_reg_write  input  1  instruction writes the register file
- i_mem_read  input  1  load
- i_mem_write  input  1  store
- i_rs_idex  input  REG_AW  source 1 of the instruction in ID/EX
- i_rt_idex  input  REG_AW  source 2 of the instruction in ID/EX
- o_valid  output  1  registered valid
- o_alu_result  output  DATA_W  registered ALU result (memory address or WB data)
- o_store_data  output  DATA_W  registered store data
- o_rd_exmem  output  REG_AW  registered destination, fed to forwarding unit
- o_pc  output  PC_W  registered PC
- o_reg_write  output  1  registered, gated by o_valid
- o_mem_read  output  1  registered, gated by o_valid
- o_mem_write  output  1  registered, gated by o_valid
- o_fwd_en  output  1  combinational: o_valid & o_reg_write & ~o_mem_read
- o_load_use_hazard  output  1  combinational load-use stall request

Behaviour:
- Reset (i_reset=1 at a rising edge): all outputs 0 on the next cycle, o_rd_exmem=0, o_valid=0. Reset overrides flush and stall.
- Priority at each edge: reset > flush > stall > load.
- Load (no reset, flush or stall):
  - all fields capture their inputs; 1-cycle latency.
  - o_valid <= i_valid.
  - control bits are captured as i_x & i_valid, so an invalid EX slot never produces side effects.
- Stall: every register holds its value; o_fwd_en and o_load_use_hazard keep evaluating from the held contents.
- Flush: o_valid, o_reg_write, o_mem_read and o_mem_write <= 0. Data fields and o_rd_exmem hold their prior values; they are don't-care when o_valid=0.
- Flush and stall together: flush wins, giving a bubble.
- o_fwd_en is the only qualifier for forwarding. The downstream mux select is (forward select & o_fwd_en). A load result is not yet available, so o_fwd_en=0 for loads.
- o_load_use_hazard = o_valid & o_mem_read & ((o_rd_exmem==i_rs_idex) | (o_rd_exmem==i_rt_idex)).
  - Purely combinational, no registered state.
  - Consumer stalls IF/ID/EX for one cycle and injects a bubble.
  - This block is not stalled by its own hazard output; the hazard clears once the load advances.
- No internal X-propagation tricks: comparisons are ordinary equality on registered values, and outputs are never X after reset.
- Back-to-back loads with no stall: each new instruction is visible on outputs exactly one cycle after presentation.

Decomposition:
- Shared package pipeline_pkg:
  - DATA_W, REG_AW and PC_W constants.
  - Control-bundle field order {reg_write, mem_read, mem_write}, so that ID/EX and MEM/WB registers reuse it.
- One natural sub-module, pipe_field_reg:
  - Parameterised width, synchronous reset, hold on stall, optional clear on flush.
  - Instantiated once for the data fields (no clear) and once for valid/control (clear).

Test Plan:
- Reset: drive i_reset=1 with all inputs at nonzero values for 2 cycles -> all outputs 0, o_fwd_en=0, o_load_use_hazard=0. Deassert -> next edge loads inputs.
- Normal ALU op: i_valid=1, i_reg_write=1, i_rd=3, i_alu_result=16'h00A5 -> one edge later o_rd_exmem=3, o_alu_result=16'h00A5, o_fwd_en=1.
- Stall hold: after the ALU-op scenario, assert i_stall with new inputs i_rd=5, i_alu_result=16'h1234 for 3 cycles -> outputs remain rd=3, 16'h00A5 throughout. Release -> rd=5 appears after one edge.
- Flush beats stall: i_stall=1 and i_flush=1 together on a valid store (i_mem_write=1) -> o_valid=0, o_mem_write=0, o_fwd_en=0 next cycle.
- Load-use: load with i_rd=2, i_mem_read=1 registered, then i_rs_idex=2 -> o_load_use_hazard=1, o_fwd_en=0. Change to i_rs_idex=4, i_rt_idex=6 -> hazard=0. Same load with i_valid=0 -> hazard=0.
- Invalid slot: i_valid=0 with i_reg_write=1 and i_mem_write=1 -> o_reg_write=0, o_mem_write=0, o_fwd_en=0.
